count_sequencer: RTL and testbench

Controller that sequences the team's 4-bit enable-gated up-counter. It issues single-cycle enable pulses at a programmable prescaled rate, measures progress from the counter's own output using modulo arithmetic (the counter has no clear), and signals completion after a programmed number of increments. It supports one-shot and auto-reload modes and sits between software-visible control registers and the counter instance.

---
 rtl/count_seq_pkg.sv | 14 +
 rtl/count_seq_prescaler.sv | 36 +++
 rtl/count_sequencer.sv | 150 +++++++++++++++
 tb/tb_count_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/count_seq_pkg.sv
// Shared types and default widths for the count sequencer and its prescaler.
package count_seq_pkg;

    localparam int CNT_W_DFLT = 4;
    localparam int PRE_W_DFLT = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRE    = 2'd1,
        TICK   = 2'd2,
        SETTLE = 2'd3
    } state_t;

endpackage

// File: rtl/count_seq_prescaler.sv
// Loadable down-counter that times the idle cycles between counter increments.
module tick_prescaler #(
    parameter int PRE_W = count_seq_pkg::PRE_W_DFLT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [PRE_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [PRE_W-1:0] cnt_q;
    logic [PRE_W-1:0] cnt_d;

    // Load wins over decrement; decrement never wraps below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/count_sequencer.sv
// Sequences an enable-gated up-counter: prescaled enable pulses, progress measured
// from the counter's own output, one-shot or auto-reload completion.
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int CNT_W = count_seq_pkg::CNT_W_DFLT,
    parameter int PRE_W = count_seq_pkg::PRE_W_DFLT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    input  logic [CNT_W-1:0] len,
    input  logic [PRE_W-1:0] prescale,
    input  logic [CNT_W-1:0] cnt_value,
    output logic             cnt_en,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] ticks,
    output logic [1:0]       dbg_state
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] base_q, base_d;
    logic [CNT_W-1:0] ticks_q, ticks_d;
    logic             cnt_en_q, cnt_en_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] delta;
    logic             pre_load;
    logic [PRE_W-1:0] pre_load_val;
    logic             pre_dec;
    logic             pre_zero;

    tick_prescaler #(.PRE_W(PRE_W)) u_prescaler (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (pre_load),
        .load_val_i (pre_load_val),
        .dec_i      (pre_dec),
        .zero_o     (pre_zero)
    );

    // The counter has no clear, so progress is its distance from the run's base.
    assign delta = cnt_value - base_q;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        pre_d        = pre_q;
        mode_d       = mode_q;
        base_d       = base_q;
        ticks_d      = ticks_q;
        cnt_en_d     = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        pre_load     = 1'b0;
        pre_load_val = pre_q;
        pre_dec      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        len_d        = len;
                        pre_d        = prescale;
                        mode_d       = auto_reload;
                        base_d       = cnt_value;
                        ticks_d      = '0;
                        pre_load     = 1'b1;
                        pre_load_val = prescale;
                        state_d      = PRE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            PRE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (pre_zero) begin
                    cnt_en_d = 1'b1;
                    state_d  = TICK;
                end else begin
                    pre_dec = 1'b1;
                end
            end
            TICK: begin
                state_d = stop ? IDLE : SETTLE;
            end
            SETTLE: begin
                // Progress is still recorded when a stop lands on this cycle.
                ticks_d = delta;
                if (stop) begin
                    state_d = IDLE;
                end else if (delta == len_q) begin
                    done_d = 1'b1;
                    if (mode_q) begin
                        base_d   = cnt_value;
                        ticks_d  = '0;
                        pre_load = 1'b1;
                        state_d  = PRE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    pre_load = 1'b1;
                    state_d  = PRE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            len_q    <= '0;
            pre_q    <= '0;
            mode_q   <= 1'b0;
            base_q   <= '0;
            ticks_q  <= '0;
            cnt_en_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            pre_q    <= pre_d;
            mode_q   <= mode_d;
            base_q   <= base_d;
            ticks_q  <= ticks_d;
            cnt_en_q <= cnt_en_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign cnt_en    = cnt_en_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign ticks     = ticks_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer driving a 4-bit enable-gated up-counter.
module tb_count_sequencer;
    import count_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       auto_reload = 1'b0;
    logic [3:0] len = '0;
    logic [7:0] prescale = '0;
    logic [3:0] cnt_value;
    logic       cnt_en;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] ticks;
    logic [1:0] dbg_state;

    // Counter under control; the load port exists only so the bench can seed a base.
    logic       cnt_rst_n;
    logic       cnt_ld = 1'b0;
    logic [3:0] cnt_ld_val = '0;
    logic [3:0] cnt_q;

    assign cnt_rst_n = !rst;
    assign cnt_value = cnt_q;

    always_ff @(posedge clk) begin
        if (!cnt_rst_n) cnt_q <= '0;
        else if (cnt_ld) cnt_q <= cnt_ld_val;
        else if (cnt_en) cnt_q <= cnt_q + 4'd1;
    end

    count_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .auto_reload (auto_reload),
        .len         (len),
        .prescale    (prescale),
        .cnt_value   (cnt_value),
        .cnt_en      (cnt_en),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .ticks       (ticks),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_done_q[$];
    logic [31:0] en_edges[$];
    logic [31:0] done_edges[$];
    logic [3:0]  ticks_at[0:63];
    int          err_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [3:0] v);
        cnt_ld = 1'b1;
        cnt_ld_val = v;
        step();
        cnt_ld = 1'b0;
    endtask

    // Issues the start sampled at edge E0 and leaves start low afterwards.
    task automatic launch(input logic mode, input logic [3:0] l, input logic [7:0] p);
        auto_reload = mode;
        len = l;
        prescale = p;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Runs n edges after E0, recording the edge index of every cnt_en/done pulse.
    task automatic capture(input int n, input int stop_at, input int restart_at);
        en_edges.delete();
        done_edges.delete();
        err_cnt = 0;
        for (int i = 1; i <= n; i++) begin
            stop = (i == stop_at);
            start = (i == restart_at);
            step();
            if (cnt_en) en_edges.push_back(32'(i));
            if (done) done_edges.push_back(32'(i));
            if (err) err_cnt++;
            if (i < 64) ticks_at[i] = ticks;
        end
        stop = 1'b0;
        start = 1'b0;
    endtask

    task automatic check_edges(input string tag);
        chk({tag, "_en_count"}, 32'(en_edges.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < en_edges.size(); i++)
            chk({tag, "_en_edge"}, en_edges[i], exp_q[i]);
        chk({tag, "_done_count"}, 32'(done_edges.size()), 32'(exp_done_q.size()));
        for (int i = 0; i < exp_done_q.size() && i < done_edges.size(); i++)
            chk({tag, "_done_edge"}, done_edges[i], exp_done_q[i]);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_cnt_en"}, 32'(cnt_en), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_ticks"}, 32'(ticks), 0);
        chk({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        check_quiet("reset");
        rst = 1'b0;
        step();

        // One-shot P=0 L=3 from base 5.
        preload(4'd5);
        launch(1'b0, 4'd3, 8'd0);
        chk("os_busy_e0", 32'(busy), 1);
        capture(12, 0, 0);
        exp_q = '{1, 4, 7};
        exp_done_q = '{9};
        check_edges("os");
        chk("os_cnt", 32'(cnt_value), 8);
        chk("os_ticks", 32'(ticks), 3);
        chk("os_busy_end", 32'(busy), 0);

        // Start (with len=0) while busy must be ignored without err or timing change.
        launch(1'b0, 4'd3, 8'd0);
        len = 4'd0;
        capture(12, 0, 5);
        exp_q = '{1, 4, 7};
        exp_done_q = '{9};
        check_edges("busy_start");
        chk("busy_start_err", 32'(err_cnt), 0);
        chk("busy_start_cnt", 32'(cnt_value), 11);

        // Rejected start.
        len = 4'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("rej_err", 32'(err), 1);
        chk("rej_busy", 32'(busy), 0);
        step();
        chk("rej_err_drop", 32'(err), 0);

        // Wrap-around: base 14, P=2, L=4.
        preload(4'd14);
        launch(1'b0, 4'd4, 8'd2);
        capture(24, 0, 0);
        exp_q = '{3, 8, 13, 18};
        exp_done_q = '{20};
        check_edges("wrap");
        chk("wrap_cnt", 32'(cnt_value), 2);
        chk("wrap_ticks", 32'(ticks), 4);
        chk("wrap_busy", 32'(busy), 0);

        // Auto-reload P=1 L=2, stopped at E0+18.
        preload(4'd9);
        launch(1'b1, 4'd2, 8'd1);
        capture(25, 18, 0);
        exp_q = '{2, 6, 10, 14};
        exp_done_q = '{8, 16};
        check_edges("ar");
        chk("ar_ticks4", 32'(ticks_at[4]), 1);
        chk("ar_ticks8", 32'(ticks_at[8]), 0);
        chk("ar_ticks12", 32'(ticks_at[12]), 1);
        chk("ar_ticks16", 32'(ticks_at[16]), 0);
        chk("ar_cnt", 32'(cnt_value), 13);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_state", 32'(dbg_state), 32'(IDLE));

        // Stop collides with completion in the final SETTLE.
        launch(1'b0, 4'd1, 8'd0);
        capture(8, 3, 0);
        exp_q = '{1};
        exp_done_q.delete();
        check_edges("coll");
        chk("coll_ticks", 32'(ticks), 1);
        chk("coll_busy", 32'(busy), 0);
        chk("coll_cnt", 32'(cnt_value), 14);

        // Reset during PRE, then a start together with stop is still honoured.
        launch(1'b0, 4'd2, 8'd3);
        step();
        step();
        chk("mid_busy_pre", 32'(busy), 1);
        rst = 1'b1;
        step();
        check_quiet("mid_rst");
        rst = 1'b0;
        step();
        auto_reload = 1'b0;
        len = 4'd1;
        prescale = 8'd0;
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        chk("ss_busy_e0", 32'(busy), 1);
        capture(6, 0, 0);
        exp_q = '{1};
        exp_done_q = '{3};
        check_edges("after_rst");
        chk("after_rst_cnt", 32'(cnt_value), 1);
        chk("after_rst_ticks", 32'(ticks), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
